// File: rtl/sdp_rdma_lat_fifo.sv
// Latency FIFO and read-credit manager for the SDP RDMA channel.
// Requests are admitted only while buffer space is reserved for their responses.
module sdp_rdma_lat_fifo #(
    parameter int REQ_W = 79,
    parameter int RSP_W = 514,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             in_req_vld,
    output logic             in_req_rdy,
    input  logic [REQ_W-1:0] in_req_pd,
    output logic             dma_rd_req_vld,
    input  logic             dma_rd_req_rdy,
    output logic [REQ_W-1:0] dma_rd_req_pd,
    input  logic             dma_rd_rsp_vld,
    output logic             dma_rd_rsp_rdy,
    input  logic [RSP_W-1:0] dma_rd_rsp_pd,
    output logic             dma_rd_cdt_lat_fifo_pop,
    output logic             out_rsp_vld,
    input  logic             out_rsp_rdy,
    output logic [RSP_W-1:0] out_rsp_pd,
    output logic [AW:0]      lat_fifo_cnt,
    output logic             idle,
    output logic             lat_fifo_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [RSP_W-1:0] mem [DEPTH];
    logic [AW:0]      credit_cnt_reg, credit_cnt_next;
    logic [AW:0]      cnt_reg, cnt_next;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic             err_reg, err_next;
    logic             cr_ok, req_acc, push, pop;

    assign cr_ok          = (credit_cnt_reg != '0);
    assign dma_rd_req_vld = in_req_vld & cr_ok;
    assign in_req_rdy     = dma_rd_req_rdy & cr_ok;
    assign dma_rd_req_pd  = in_req_pd;
    assign req_acc        = dma_rd_req_vld & dma_rd_req_rdy;

    assign dma_rd_rsp_rdy = (cnt_reg != DEPTH_C);
    assign push           = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    assign out_rsp_vld    = (cnt_reg != '0);
    assign out_rsp_pd     = mem[rd_ptr_reg];
    assign pop            = out_rsp_vld & out_rsp_rdy;

    assign dma_rd_cdt_lat_fifo_pop = pop;
    assign lat_fifo_cnt            = cnt_reg;
    assign idle                    = (credit_cnt_reg == DEPTH_C) & (cnt_reg == '0);
    assign lat_fifo_err            = err_reg;

    always_comb begin
        credit_cnt_next = credit_cnt_reg;
        unique case ({req_acc, pop})
            2'b10:   credit_cnt_next = credit_cnt_reg - 1'b1;
            // A pop with every credit already home is a protocol error; hold at DEPTH.
            2'b01:   credit_cnt_next = (credit_cnt_reg == DEPTH_C) ? credit_cnt_reg
                                                                   : credit_cnt_reg + 1'b1;
            default: credit_cnt_next = credit_cnt_reg;
        endcase

        cnt_next = cnt_reg;
        unique case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase

        err_next = err_reg;
        if (dma_rd_rsp_vld && (cnt_reg == DEPTH_C))
            err_next = 1'b1;
        if (pop && !req_acc && (credit_cnt_reg == DEPTH_C))
            err_next = 1'b1;
        if (({1'b0, credit_cnt_reg} + {1'b0, cnt_reg}) > {1'b0, DEPTH_C})
            err_next = 1'b1;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            credit_cnt_reg <= DEPTH_C;
            cnt_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            credit_cnt_reg <= credit_cnt_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge nvdla_core_clk) begin
        if (push)
            mem[wr_ptr_reg] <= dma_rd_rsp_pd;
    end

endmodule

// File: tb/tb_sdp_rdma_lat_fifo.sv
// Directed bench for sdp_rdma_lat_fifo: credit gating, ordering, latency, errors, reset.
module tb_sdp_rdma_lat_fifo;

    localparam int REQ_W = 79;
    localparam int RSP_W = 514;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_req_vld, in_req_rdy;
    logic [REQ_W-1:0] in_req_pd;
    logic             dma_rd_req_vld, dma_rd_req_rdy;
    logic [REQ_W-1:0] dma_rd_req_pd;
    logic             dma_rd_rsp_vld, dma_rd_rsp_rdy;
    logic [RSP_W-1:0] dma_rd_rsp_pd;
    logic             cdt_pop;
    logic             out_rsp_vld, out_rsp_rdy;
    logic [RSP_W-1:0] out_rsp_pd;
    logic [AW:0]      lat_fifo_cnt;
    logic             idle, lat_fifo_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdp_rdma_lat_fifo #(.REQ_W(REQ_W), .RSP_W(RSP_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rst          (rst),
        .in_req_vld              (in_req_vld),
        .in_req_rdy              (in_req_rdy),
        .in_req_pd               (in_req_pd),
        .dma_rd_req_vld          (dma_rd_req_vld),
        .dma_rd_req_rdy          (dma_rd_req_rdy),
        .dma_rd_req_pd           (dma_rd_req_pd),
        .dma_rd_rsp_vld          (dma_rd_rsp_vld),
        .dma_rd_rsp_rdy          (dma_rd_rsp_rdy),
        .dma_rd_rsp_pd           (dma_rd_rsp_pd),
        .dma_rd_cdt_lat_fifo_pop (cdt_pop),
        .out_rsp_vld             (out_rsp_vld),
        .out_rsp_rdy             (out_rsp_rdy),
        .out_rsp_pd              (out_rsp_pd),
        .lat_fifo_cnt            (lat_fifo_cnt),
        .idle                    (idle),
        .lat_fifo_err            (lat_fifo_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue_reqs(input int n);
        in_req_vld     = 1'b1;
        dma_rd_req_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_req_pd = REQ_W'(i + 32'h100);
            step();
        end
        in_req_vld = 1'b0;
    endtask

    task automatic push_rsps(input int n, input int base);
        dma_rd_rsp_vld = 1'b1;
        for (int i = 0; i < n; i++) begin
            dma_rd_rsp_pd = RSP_W'(base + i);
            step();
        end
        dma_rd_rsp_vld = 1'b0;
    endtask

    task automatic check_clean(input string tag);
        @(negedge clk);
        chk({tag, "_cnt"},    64'(lat_fifo_cnt),       64'd0);
        chk({tag, "_credit"}, 64'(dut.credit_cnt_reg), 64'd16);
        chk({tag, "_idle"},   64'(idle),               64'd1);
        chk({tag, "_err"},    64'(lat_fifo_err),       64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int pops;

        rst            = 1'b1;
        in_req_vld     = 1'b0;
        in_req_pd      = '0;
        dma_rd_req_rdy = 1'b0;
        dma_rd_rsp_vld = 1'b0;
        dma_rd_rsp_pd  = '0;
        out_rsp_rdy    = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cnt",      64'(lat_fifo_cnt),   64'd0);
        chk("rst_out_vld",  64'(out_rsp_vld),    64'd0);
        chk("rst_pop",      64'(cdt_pop),        64'd0);
        chk("rst_req_vld",  64'(dma_rd_req_vld), 64'd0);
        chk("rst_idle",     64'(idle),           64'd1);
        chk("rst_err",      64'(lat_fifo_err),   64'd0);
        chk("rst_rsp_rdy",  64'(dma_rd_rsp_rdy), 64'd1);
        step();

        // Credit exhaustion: 20 cycles of requests yield exactly 16 accepts
        acc            = 0;
        in_req_vld     = 1'b1;
        dma_rd_req_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_req_pd = REQ_W'(i + 32'h55);
            @(negedge clk);
            if (i == 3)
                chk("req_pd_pass", 64'(dma_rd_req_pd), 64'h58);
            if (dma_rd_req_vld && dma_rd_req_rdy)
                acc++;
            step();
        end
        @(negedge clk);
        chk("req_acc_count",  64'(acc),                 64'd16);
        chk("req_vld_gated",  64'(dma_rd_req_vld),      64'd0);
        chk("req_rdy_gated",  64'(in_req_rdy),          64'd0);
        chk("credit_zero",    64'(dut.credit_cnt_reg),  64'd0);
        chk("idle_busy",      64'(idle),                64'd0);
        step();
        in_req_vld = 1'b0;

        // Fill with payloads 0..15, then drain in order
        push_rsps(16, 0);
        @(negedge clk);
        chk("full_cnt",     64'(lat_fifo_cnt),   64'd16);
        chk("full_rsp_rdy", 64'(dma_rd_rsp_rdy), 64'd0);
        chk("full_out_vld", 64'(out_rsp_vld),    64'd1);
        step();
        out_rsp_rdy = 1'b1;
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("drain_pd%0d", i), 64'(out_rsp_pd), 64'(i));
            if (cdt_pop)
                pops++;
            step();
        end
        out_rsp_rdy = 1'b0;
        chk("drain_pops", 64'(pops), 64'd16);
        check_clean("drained");
        step();

        // Single-entry latency with consumer ready
        issue_reqs(1);
        out_rsp_rdy    = 1'b1;
        dma_rd_rsp_vld = 1'b1;
        dma_rd_rsp_pd  = RSP_W'(32'hAB);
        @(negedge clk);
        chk("lat_n_vld", 64'(out_rsp_vld), 64'd0);
        chk("lat_n_pop", 64'(cdt_pop),     64'd0);
        step();
        dma_rd_rsp_vld = 1'b0;
        @(negedge clk);
        chk("lat_n1_vld", 64'(out_rsp_vld), 64'd1);
        chk("lat_n1_pop", 64'(cdt_pop),     64'd1);
        chk("lat_n1_pd",  64'(out_rsp_pd),  64'hAB);
        step();
        out_rsp_rdy = 1'b0;
        check_clean("lat_n2");
        step();

        // Steady streaming at occupancy 3, credit 8
        issue_reqs(8);
        push_rsps(3, 0);
        in_req_vld     = 1'b1;
        dma_rd_rsp_vld = 1'b1;
        out_rsp_rdy    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dma_rd_rsp_pd = RSP_W'(i + 3);
            @(negedge clk);
            chk($sformatf("stream_pd%0d", i), 64'(out_rsp_pd), 64'(i));
            step();
        end
        in_req_vld     = 1'b0;
        dma_rd_rsp_vld = 1'b0;
        out_rsp_rdy    = 1'b0;
        @(negedge clk);
        chk("stream_cnt",    64'(lat_fifo_cnt),      64'd3);
        chk("stream_credit", 64'(dut.credit_cnt_reg), 64'd8);
        chk("stream_err",    64'(lat_fifo_err),      64'd0);
        step();
        do_reset();

        // Overflow injection while full
        issue_reqs(16);
        push_rsps(16, 32'h40);
        @(negedge clk);
        chk("ovf_pre_err", 64'(lat_fifo_err), 64'd0);
        step();
        dma_rd_rsp_vld = 1'b1;
        dma_rd_rsp_pd  = RSP_W'(32'h99);
        step();
        dma_rd_rsp_vld = 1'b0;
        @(negedge clk);
        chk("ovf_err",  64'(lat_fifo_err), 64'd1);
        chk("ovf_cnt",  64'(lat_fifo_cnt), 64'd16);
        chk("ovf_head", 64'(out_rsp_pd),   64'h40);
        step();
        step();
        @(negedge clk);
        chk("ovf_err_sticky", 64'(lat_fifo_err), 64'd1);
        step();
        do_reset();
        check_clean("ovf_rst");
        step();

        // Reset mid-stream at occupancy 7, credit 5
        issue_reqs(11);
        push_rsps(7, 0);
        @(negedge clk);
        chk("mid_cnt",    64'(lat_fifo_cnt),       64'd7);
        chk("mid_credit", 64'(dut.credit_cnt_reg), 64'd5);
        step();
        out_rsp_rdy = 1'b1;
        do_reset();
        @(negedge clk);
        chk("mid_rst_cnt",    64'(lat_fifo_cnt),       64'd0);
        chk("mid_rst_credit", 64'(dut.credit_cnt_reg), 64'd16);
        chk("mid_rst_vld",    64'(out_rsp_vld),        64'd0);
        chk("mid_rst_pop",    64'(cdt_pop),            64'd0);
        step();
        out_rsp_rdy    = 1'b0;
        in_req_vld     = 1'b1;
        dma_rd_req_rdy = 1'b1;
        @(negedge clk);
        chk("post_rst_req_vld", 64'(dma_rd_req_vld), 64'd1);
        chk("post_rst_req_rdy", 64'(in_req_rdy),     64'd1);
        step();
        in_req_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_credit", 64'(dut.credit_cnt_reg), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
